// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, mouse command bytes, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE,
    DONE,
    ERR
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus falling-edge detect on the synchronized value.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Lines idle high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-collector clock/data via pull-low enables.
//
// state     | meaning
// IDLE      | ready for a command byte
// INHIBIT   | clock held low (request-to-send)
// REQ       | start bit on data, clock released
// DATA      | shift data bits, parity and stop on device clock falls
// ACK       | sample device acknowledge on 11th fall
// WAIT_IDLE | wait for both lines to float high
// DONE      | tx_done pulse
// ERR       | lines released, tx_err pulse
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 4000,
  parameter int TIMEOUT_CYCLES = 600000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // Inhibit load is two short: REQ adds the final low-clock cycle and the oe flop adds the latency.
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] WD_LOAD  = CW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t state_q, state_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          dmeta_q, dmeta_d, dsync_q, dsync_d;
  logic          clk_sync, clk_fall;
  logic          wd_expired;

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .rst_n  (rst),
    .async_i(ps2_clk_i),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  assign wd_expired = (cnt_q == '0) && !clk_fall;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    dmeta_d   = ps2_data_i;
    dsync_d   = dmeta_q;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = {odd_parity(tx_data), tx_data};
          cnt_d     = INH_LOAD;
          bit_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == '0) begin
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      REQ: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        bit_cnt_d = '0;
        cnt_d     = WD_LOAD;
        state_d   = DATA;
      end
      DATA, ACK, WAIT_IDLE: begin
        if (clk_fall)
          cnt_d = WD_LOAD;
        else if (!wd_expired)
          cnt_d = cnt_q - CW'(1);

        if (wd_expired) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = ERR;
        end else if (state_q == DATA) begin
          if (clk_fall) begin
            if (bit_cnt_q == 4'd9) begin
              data_oe_d = 1'b0;
              state_d   = ACK;
            end else begin
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b0, shift_q[8:1]};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end else if (state_q == ACK) begin
          if (clk_fall)
            state_d = dsync_q ? ERR : WAIT_IDLE;
        end else if (clk_sync && dsync_q) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      dmeta_q   <= 1'b1;
      dsync_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      dmeta_q   <= dmeta_d;
      dsync_q   <= dsync_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = (state_q == DONE);
  assign tx_err      = (state_q == ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a wired-AND PS/2 device model (compressed clock period).
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 400;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_i, ps2_data_i;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;

  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  typedef struct {
    bit          done;
    bit          err;
    bit          chk_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [10:0] cap_frame = '0;
  int          inh_run = 0;
  int          inh_len = 0;
  logic        data_at_rel = 1'b0;
  logic        last_data = 1'b0;
  int          n_acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      inh_run   <= inh_run + 1;
      last_data <= ps2_data_oe;
    end else if (inh_run != 0) begin
      inh_len     <= inh_run;
      data_at_rel <= last_data;
      inh_run     <= 0;
    end
    if (rst_n && tx_valid && tx_ready) n_acc <= n_acc + 1;
  end

  // Monitor: each tx_done/tx_err pulse is matched against the oldest expected outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (tx_done || tx_err)) begin
        if (exp_q.size() == 0) begin
          bound_fail("unexpected_pulse");
        end else begin
          e = exp_q.pop_front();
          chk("done_flag", int'(tx_done), int'(e.done));
          chk("err_flag", int'(tx_err), int'(e.err));
          if (e.chk_frame) chk("line_frame", int'(cap_frame), int'(e.frame));
          @(negedge clk);
          chk("pulse_one_cycle", int'(tx_done | tx_err), 0);
          chk("ready_after", int'(tx_ready), 1);
        end
      end
    end
  end

  task automatic push(input bit done, input bit chk_frame, input logic [10:0] frame);
    exp_t e;
    e.done = done; e.err = ~done; e.chk_frame = chk_frame; e.frame = frame;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) bound_fail("send_ready");
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_clk_oe(input logic v, input int budget, input string name);
    int n = 0;
    while (ps2_clk_oe !== v && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) bound_fail(name);
  endtask

  task automatic dev_run(input int nfalls, input bit ack);
    wait_clk_oe(1'b1, 50, "dev_wait_inhibit");
    wait_clk_oe(1'b0, INH + 50, "dev_wait_release");
    cap_frame[0] = ps2_data_i;
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      if (k <= nfalls) begin
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        cap_frame[k] = ps2_data_i;
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
      end
    end
    if (nfalls >= 11) begin
      if (ack) dev_data = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) bound_fail(name);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat;
    int acc_base;

    #3;
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_err", int'(tx_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xF4: {stop=1, parity=0, F4, start=0}
    push(1'b1, 1'b1, 11'h5E8);
    send(8'hF4);
    chk("busy_in_frame", int'(busy), 1);
    dev_run(11, 1'b1);
    wait_drain("drain_f4");
    chk("inhibit_len_f4", inh_len, INH);
    chk("start_before_release", int'(data_at_rel), 1);

    // 0x00: parity 1
    push(1'b1, 1'b1, 11'h600);
    send(8'h00);
    dev_run(11, 1'b1);
    wait_drain("drain_00");
    chk("inhibit_len_00", inh_len, INH);

    // device never clocks
    push(1'b0, 1'b0, 11'h000);
    send(8'h55);
    wait_clk_oe(1'b1, 50, "tmo_wait_inhibit");
    wait_clk_oe(1'b0, INH + 50, "tmo_wait_release");
    lat = 0;
    while (!tx_err && lat < 2 * TMO) begin @(negedge clk); lat++; end
    if (lat >= 2 * TMO) bound_fail("tmo_err");
    chk("tmo_window", int'(lat >= TMO - 1 && lat <= TMO + 3), 1);
    chk("tmo_clk_oe", int'(ps2_clk_oe), 0);
    chk("tmo_data_oe", int'(ps2_data_oe), 0);
    wait_drain("drain_tmo");
    chk("tmo_ready", int'(tx_ready), 1);

    // no acknowledge: 0xFF, parity 1
    push(1'b0, 1'b1, 11'h7FE);
    send(8'hFF);
    dev_run(11, 1'b0);
    wait_drain("drain_noack");

    // async reset during INHIBIT
    send(8'hF4);
    repeat (4) @(negedge clk);
    chk("inh_clk_oe_pre", int'(ps2_clk_oe), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("inh_rst_clk_oe", int'(ps2_clk_oe), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // async reset in DATA after fall 4 (bit3 of F4 is 0 -> data pulled low)
    send(8'hF4);
    dev_run(4, 1'b0);
    chk("data_oe_pre_rst", int'(ps2_data_oe), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_mid_data_oe", int'(ps2_data_oe), 0);
    chk("rst_mid_ready", int'(tx_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

    // hold tx_valid with 0xF3 (parity 1) across the frame
    acc_base = n_acc;
    push(1'b1, 1'b1, 11'h7E6);
    @(posedge clk); #1;
    tx_data  = 8'hF3;
    tx_valid = 1'b1;
    dev_run(11, 1'b1);
    wait_drain("drain_hold1");
    chk("hold_accepts", n_acc - acc_base, 2);
    chk("hold_second_busy", int'(busy), 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    push(1'b1, 1'b1, 11'h7E6);
    dev_run(11, 1'b1);
    wait_drain("drain_hold2");
    chk("hold_accepts_final", n_acc - acc_base, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1);
  end

endmodule
